// File: rtl/demux_1x8_dispatcher.sv
// ---------------------------------------------------------------------------
// demux_1x8_dispatcher
//
// Sequencing front-end for a 1x8 demultiplexer. Words arrive on a
// valid/ready input and are held in a one-word register, then offered to one
// of 8 output channels. The channel is either given with the word (directed
// mode, in_dest) or taken from a round-robin pointer (mode=1). A held word
// that is not taken within TIMEOUT cycles is dropped (directed) or moved on
// to the next channel (round-robin), so one blocked channel cannot stall the
// input forever.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_valid    input word valid
//   in_ready    dispatcher can accept a word this cycle (combinational)
//   in_data     input word (DW bits)
//   in_dest     destination channel, used in directed mode only
//   mode        0 = directed, 1 = round-robin; sampled at accept
//   out_data    held word, shared by all channels
//   out_valid   one-hot valid, bit sel set while a word is held
//   out_ready   per-channel ready
//   sel         current destination, drives the demux select
//   busy        high while a word is held
//   drop_pulse  one-cycle pulse when a word is dropped
//   drop_cnt    saturating count of dropped words
// ---------------------------------------------------------------------------
module demux_1x8_dispatcher #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [2:0]    in_dest,
    input  logic          mode,
    output logic [DW-1:0] out_data,
    output logic [7:0]    out_valid,
    input  logic [7:0]    out_ready,
    output logic [2:0]    sel,
    output logic          busy,
    output logic          drop_pulse,
    output logic [7:0]    drop_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_r;
    logic [2:0]  rr_ptr_r;
    logic [7:0]  stall_cnt_r;
    logic        m_q_r;

    logic        deliver_s;
    logic        accept_s;
    logic        timeout_s;
    logic [2:0]  next_sel_s;

    // One-hot channel valid vector for a channel index.
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        onehot8 = 8'(8'd1 << idx);
    endfunction

    // Handshake decode: delivery, accept and timeout conditions for this cycle.
    always_comb begin
        deliver_s  = 1'b0;
        accept_s   = 1'b0;
        timeout_s  = 1'b0;
        in_ready   = 1'b0;
        next_sel_s = 3'd0;
        if (state_r == HOLD) begin
            deliver_s = out_ready[sel];
        end else begin
            deliver_s = 1'b0;
        end
        // A delivery frees the holding register in the same cycle, which is
        // what allows one word per cycle back-to-back.
        in_ready  = (state_r == IDLE) || deliver_s;
        accept_s  = in_valid && in_ready;
        // Delivery has priority: the timeout only fires without a delivery.
        timeout_s = (state_r == HOLD) && !deliver_s &&
                    (stall_cnt_r == 8'(TIMEOUT - 1));
        if (mode) begin
            next_sel_s = rr_ptr_r;
        end else begin
            next_sel_s = in_dest;
        end
    end

    // Holding register, FSM, round-robin pointer, stall timer and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            out_data    <= '0;
            out_valid   <= 8'd0;
            sel         <= 3'd0;
            busy        <= 1'b0;
            rr_ptr_r    <= 3'd0;
            stall_cnt_r <= 8'd0;
            m_q_r       <= 1'b0;
            drop_pulse  <= 1'b0;
            drop_cnt    <= 8'd0;
        end else begin
            drop_pulse <= 1'b0;
            if (accept_s) begin
                state_r     <= HOLD;
                out_data    <= in_data;
                sel         <= next_sel_s;
                out_valid   <= onehot8(next_sel_s);
                busy        <= 1'b1;
                m_q_r       <= mode;
                stall_cnt_r <= 8'd0;
                if (mode) begin
                    rr_ptr_r <= rr_ptr_r + 3'd1;
                end
            end else if (deliver_s) begin
                state_r   <= IDLE;
                out_valid <= 8'd0;
                busy      <= 1'b0;
            end else if (state_r == HOLD) begin
                if (timeout_s) begin
                    if (!m_q_r) begin
                        state_r    <= IDLE;
                        out_valid  <= 8'd0;
                        busy       <= 1'b0;
                        drop_pulse <= 1'b1;
                        if (drop_cnt != 8'hFF) begin
                            drop_cnt <= drop_cnt + 8'd1;
                        end
                    end else begin
                        // Re-route to the next channel; the pointer skips past
                        // it so the next new word does not land there too.
                        sel         <= sel + 3'd1;
                        out_valid   <= onehot8(sel + 3'd1);
                        stall_cnt_r <= 8'd0;
                        rr_ptr_r    <= sel + 3'd2;
                    end
                end else begin
                    stall_cnt_r <= stall_cnt_r + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_1x8_dispatcher.sv
// ---------------------------------------------------------------------------
// Self-checking bench for demux_1x8_dispatcher. A behavioural model of the
// dispatcher (held word, destination, age in cycles, round-robin pointer,
// total drop count) is compared against the DUT outputs every cycle, with a
// few hand-computed literal expectations for the directed scenarios.
// ---------------------------------------------------------------------------
module tb_demux_1x8_dispatcher;

    localparam int DW      = 8;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [2:0]    in_dest;
    logic          mode;
    logic [DW-1:0] out_data;
    logic [7:0]    out_valid;
    logic [7:0]    out_ready;
    logic [2:0]    sel;
    logic          busy;
    logic          drop_pulse;
    logic [7:0]    drop_cnt;

    demux_1x8_dispatcher #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .mode       (mode),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sel        (sel),
        .busy       (busy),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit         m_held;
    logic [7:0] m_word;
    int         m_dest;
    bit         m_rrmode;
    int         m_age;
    int         m_rr;
    int         m_drops;
    bit         m_pulse;

    // Last observed DUT outputs
    logic [7:0] obs_valid;
    logic [2:0] obs_sel;
    logic [7:0] obs_data;
    logic       obs_pulse;
    logic       obs_in_ready;
    logic       obs_busy;
    logic [7:0] obs_drop_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_held   = 1'b0;
        m_word   = 8'd0;
        m_dest   = 0;
        m_rrmode = 1'b0;
        m_age    = 0;
        m_rr     = 0;
        m_drops  = 0;
        m_pulse  = 1'b0;
    endtask

    // Advance the model across one clock edge with the given inputs.
    task automatic model_step(input logic iv, input logic [7:0] d, input logic [2:0] dst,
                              input logic md, input logic [7:0] ord);
        bit dlv;
        dlv     = m_held && ord[m_dest];
        m_pulse = 1'b0;
        if (m_held && !dlv) begin
            m_age++;
            if (m_age == TIMEOUT) begin
                if (!m_rrmode) begin
                    m_held  = 1'b0;
                    m_drops++;
                    m_pulse = 1'b1;
                end else begin
                    m_dest = (m_dest + 1) % 8;
                    m_rr   = (m_dest + 1) % 8;
                    m_age  = 0;
                end
            end
        end else if (iv) begin
            m_held   = 1'b1;
            m_word   = d;
            m_rrmode = md;
            m_age    = 0;
            if (md) begin
                m_dest = m_rr;
                m_rr   = (m_rr + 1) % 8;
            end else begin
                m_dest = int'(dst);
            end
        end else begin
            m_held = 1'b0;
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs with the model, step.
    task automatic cycle(input logic iv, input logic [7:0] d, input logic [2:0] dst,
                         input logic md, input logic [7:0] ord);
        logic [7:0] exp_v;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_dest   = dst;
        mode      = md;
        out_ready = ord;
        #1;
        obs_valid    = out_valid;
        obs_sel      = sel;
        obs_data     = out_data;
        obs_pulse    = drop_pulse;
        obs_in_ready = in_ready;
        obs_busy     = busy;
        obs_drop_cnt = drop_cnt;
        exp_v = m_held ? 8'(8'd1 << m_dest) : 8'd0;
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        chk("out_data", 32'(out_data), 32'(m_word));
        chk("sel", 32'(sel), 32'(m_dest));
        chk("busy", 32'(busy), 32'(m_held));
        chk("drop_pulse", 32'(drop_pulse), 32'(m_pulse));
        chk("drop_cnt", 32'(drop_cnt), (m_drops > 255) ? 32'd255 : 32'(m_drops));
        chk("in_ready", 32'(in_ready), 32'(!m_held || ord[m_dest]));
        model_step(iv, d, dst, md, ord);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_v;
        int pulses;
        logic [7:0] ord;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_dest = 3'd0; mode = 1'b0; out_ready = 8'd0;
        model_reset();
        @(negedge clk); #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // 1. Directed delivery
        cycle(1'b1, 8'hA5, 3'd3, 1'b0, 8'h08);
        cycle(1'b0, 8'h00, 3'd0, 1'b0, 8'h08);
        chk("t1_valid", 32'(obs_valid), 32'h08);
        chk("t1_sel", 32'(obs_sel), 32'd3);
        chk("t1_data", 32'(obs_data), 32'hA5);
        cycle(1'b0, 8'h00, 3'd0, 1'b0, 8'h08);
        chk("t1_idle_valid", 32'(obs_valid), 32'h00);
        chk("t1_ready", 32'(obs_in_ready), 32'd1);
        chk("t1_drops", 32'(obs_drop_cnt), 32'd0);

        // 2. Round-robin back-to-back, one word per cycle
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(i), 3'd7, 1'b1, 8'hFF);
            chk("t2_ready", 32'(obs_in_ready), 32'd1);
            if (i > 0) chk("t2_sel", 32'(obs_sel), 32'((i - 1) % 8));
        end
        cycle(1'b0, 8'h00, 3'd0, 1'b1, 8'hFF);
        chk("t2_last_sel", 32'(obs_sel), 32'd1);
        chk("t2_last_data", 32'(obs_data), 32'd9);

        // 4. RR re-route: pointer is now 2, only channel 3 is ready
        cycle(1'b1, 8'h44, 3'd0, 1'b1, 8'h08);
        cnt_v = 0;
        for (int k = 0; k < 15; k++) begin
            cycle(1'b0, 8'h00, 3'd0, 1'b1, 8'h08);
            if (obs_valid == 8'h04) cnt_v++;
        end
        chk("t4_wait_ch2", 32'(cnt_v), 32'd15);
        cycle(1'b0, 8'h00, 3'd0, 1'b1, 8'h08);
        chk("t4_reroute_sel", 32'(obs_sel), 32'd3);
        chk("t4_reroute_valid", 32'(obs_valid), 32'h08);
        chk("t4_deliver", 32'(obs_in_ready), 32'd1);
        cycle(1'b1, 8'h55, 3'd0, 1'b1, 8'h00);
        cycle(1'b0, 8'h00, 3'd0, 1'b1, 8'hFF);
        chk("t4_next_sel", 32'(obs_sel), 32'd4);

        // 3. Directed timeout and drop
        cycle(1'b1, 8'h3C, 3'd5, 1'b0, 8'h00);
        cnt_v = 0; pulses = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
            if (obs_valid == 8'h20) cnt_v++;
            if (obs_pulse) pulses++;
        end
        chk("t3_held_cycles", 32'(cnt_v), 32'd15);
        chk("t3_pulses", 32'(pulses), 32'd1);
        chk("t3_drop_cnt", 32'(obs_drop_cnt), 32'd1);
        chk("t3_idle", 32'(obs_busy), 32'd0);
        for (int k = 0; k < 300 * 16; k++) cycle(1'b1, 8'(k), 3'd5, 1'b0, 8'h00);
        for (int k = 0; k < 17; k++) cycle(1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
        chk("t3_saturated", 32'(obs_drop_cnt), 32'd255);

        // 5. Boundary: ready on the 15th held cycle delivers, no drop
        cycle(1'b1, 8'h77, 3'd1, 1'b0, 8'h00);
        for (int k = 1; k <= 15; k++) begin
            cycle(1'b0, 8'h00, 3'd0, 1'b0, (k == 15) ? 8'h02 : 8'h00);
        end
        chk("t5_last_valid", 32'(obs_valid), 32'h02);
        chk("t5_last_ready", 32'(obs_in_ready), 32'd1);
        cycle(1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
        chk("t5_no_pulse", 32'(obs_pulse), 32'd0);
        chk("t5_idle", 32'(obs_valid), 32'h00);
        // in_dest ignored in round-robin mode; pointer is 5 here
        cycle(1'b1, 8'h66, 3'd6, 1'b1, 8'h00);
        cycle(1'b0, 8'h00, 3'd6, 1'b1, 8'hFF);
        chk("t5_rr_sel", 32'(obs_sel), 32'd5);

        // 6. Asynchronous reset mid-HOLD
        cycle(1'b1, 8'h99, 3'd0, 1'b1, 8'h00);
        cycle(1'b0, 8'h00, 3'd0, 1'b1, 8'h00);
        chk("t6_busy_before", 32'(obs_busy), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_sel", 32'(sel), 32'd0);
        chk("t6_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        model_reset();
        #1 rst = 1'b0;
        cycle(1'b1, 8'h11, 3'd3, 1'b1, 8'hFF);
        cycle(1'b0, 8'h00, 3'd0, 1'b1, 8'hFF);
        chk("t6_first_sel", 32'(obs_sel), 32'd0);
        chk("t6_first_valid", 32'(obs_valid), 32'h01);

        // Randomized traffic with varying ready density to hit timeouts
        for (int p = 0; p < 20; p++) begin
            int dens;
            dens = $urandom_range(0, 3);
            for (int k = 0; k < 100; k++) begin
                case (dens)
                    0:       ord = 8'h00;
                    1:       ord = 8'($urandom) & 8'($urandom) & 8'($urandom);
                    2:       ord = 8'($urandom);
                    default: ord = 8'hFF;
                endcase
                cycle(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom),
                      1'($urandom_range(0, 1)), ord);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
